// File: rtl/motion_sequencer_pkg.sv
// Shared types and constants for the four-joint motion sequencer.
// Holds the FSM state encoding, joint geometry and the single-joint step helper.
package motion_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int NUM_JOINTS = 4;
  localparam int JOINT_W    = 8;
  localparam logic [JOINT_W-1:0] CENTRE = 8'h80;

  // Moves one joint a single count toward its target; saturates naturally at the target.
  function automatic logic [JOINT_W-1:0] step_toward(input logic [JOINT_W-1:0] cur,
                                                     input logic [JOINT_W-1:0] tgt);
    if (cur < tgt)      step_toward = cur + JOINT_W'(1);
    else if (cur > tgt) step_toward = cur - JOINT_W'(1);
    else                step_toward = cur;
  endfunction

endpackage

// File: rtl/motion_sequencer_tick_gen.sv
// Divides the clock down to a one-cycle motion tick every TICK_DIV cycles.
// The counter is held at zero whenever enable is low.
module tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/motion_sequencer.sv
// Steps four 8-bit joints through a small waypoint table, one count per tick,
// dwelling HOLD_TICKS ticks at each waypoint before advancing.
module motion_sequencer
  import motion_sequencer_pkg::*;
#(
  parameter int TICK_DIV   = 500000,
  parameter int HOLD_TICKS = 50,
  parameter int NUM_WP     = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      wp_we,
  input  logic [$clog2(NUM_WP)-1:0] wp_addr,
  input  logic [31:0]               wp_data,
  input  logic [$clog2(NUM_WP)-1:0] last_wp,
  output logic [31:0]               pos,
  output logic [$clog2(NUM_WP)-1:0] wp_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int AW = $clog2(NUM_WP);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [31:0] CENTRE_WORD = {NUM_JOINTS{CENTRE}};

  state_t        state;
  logic [31:0]   wp_table [NUM_WP];
  logic [AW-1:0] last_q;
  logic [HW-1:0] hold_cnt;
  logic [31:0]   target;
  logic [31:0]   stepped;
  logic          at_target;
  logic          enable;
  logic          tick;

  assign target    = wp_table[wp_idx];
  assign at_target = (pos == target);

  always_comb begin
    stepped = pos;
    for (int j = 0; j < NUM_JOINTS; j++) begin
      stepped[j*JOINT_W +: JOINT_W] = step_toward(pos[j*JOINT_W +: JOINT_W],
                                                  target[j*JOINT_W +: JOINT_W]);
    end
  end

  // Dropping enable on the MOVE->HOLD cycle restarts the divider, so a dwell
  // is always a whole number of tick periods regardless of arrival phase.
  assign enable = (state != IDLE) && !stop && !((state == MOVE) && at_target);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_WP; i++) begin
        wp_table[i] <= CENTRE_WORD;
      end
    end else if (wp_we && (state == IDLE)) begin
      wp_table[wp_addr] <= wp_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= CENTRE_WORD;
      wp_idx   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      last_q   <= '0;
      hold_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state  <= MOVE;
            busy   <= 1'b1;
            wp_idx <= '0;
            last_q <= last_wp;
          end
        end
        MOVE: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (at_target) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end else if (tick) begin
            pos <= stepped;
          end
        end
        HOLD: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              if (wp_idx == last_q) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state  <= MOVE;
                wp_idx <= wp_idx + AW'(1);
              end
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer with TICK_DIV=4, HOLD_TICKS=2, NUM_WP=8.
module tb_motion_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        wp_we = 1'b0;
  logic [2:0]  wp_addr = '0;
  logic [31:0] wp_data = '0;
  logic [2:0]  last_wp = '0;
  logic [31:0] pos;
  logic [2:0]  wp_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  motion_sequencer #(
    .TICK_DIV  (4),
    .HOLD_TICKS(2),
    .NUM_WP    (8)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .wp_we  (wp_we),
    .wp_addr(wp_addr),
    .wp_data(wp_data),
    .last_wp(last_wp),
    .pos    (pos),
    .wp_idx (wp_idx),
    .busy   (busy),
    .done   (done)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic write_wp(input logic [2:0] a, input logic [31:0] d);
    wp_we = 1'b1;
    wp_addr = a;
    wp_data = d;
    cyc();
    wp_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] lw);
    start = 1'b1;
    last_wp = lw;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc();
    checks++; if (pos !== 32'h80808080) begin failures++; $display("FAIL reset_pos got=%h exp=80808080", pos); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (wp_idx !== 3'd0) begin failures++; $display("FAIL reset_wp_idx got=%0d exp=0", wp_idx); end
  endtask

  task automatic test_single();
    int done_at;
    int ndone;
    done_at = 0;
    ndone = 0;
    do_reset();
    write_wp(3'd0, 32'h80808083);
    pulse_start(3'd0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_rise got=%b exp=1", busy); end
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (c == 3) begin
        checks++; if (pos !== 32'h80808080) begin failures++; $display("FAIL single_pre_tick got=%h exp=80808080", pos); end
      end
      if (c == 4) begin
        checks++; if (pos !== 32'h80808081) begin failures++; $display("FAIL single_tick1 got=%h exp=80808081", pos); end
      end
      if (c == 12) begin
        checks++; if (pos !== 32'h80808083) begin failures++; $display("FAIL single_tick3 got=%h exp=80808083", pos); end
      end
      if (c == 20) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_hold_busy got=%b exp=1", busy); end
      end
      if (done) begin
        ndone++;
        if (done_at == 0) done_at = c;
      end
    end
    checks++; if (done_at !== 21) begin failures++; $display("FAIL single_done_time got=%0d exp=21", done_at); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", ndone); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
    checks++; if (pos !== 32'h80808083) begin failures++; $display("FAIL single_final_pos got=%h exp=80808083", pos); end
  endtask

  task automatic test_two_wp();
    int done_at;
    int ndone;
    int wraps;
    logic [7:0] prev0;
    logic [7:0] max0;
    done_at = 0;
    ndone = 0;
    wraps = 0;
    max0 = 8'h00;
    do_reset();
    write_wp(3'd0, 32'h7F8080FF);
    write_wp(3'd1, 32'h80808080);
    pulse_start(3'd1);
    prev0 = pos[7:0];
    for (int c = 1; c <= 1100; c++) begin
      cyc();
      if (c == 4) begin
        checks++; if (pos !== 32'h7F808081) begin failures++; $display("FAIL two_first_step got=%h exp=7F808081", pos); end
      end
      if (c == 508) begin
        checks++; if (pos !== 32'h7F8080FF) begin failures++; $display("FAIL two_reach_wp0 got=%h exp=7F8080FF", pos); end
      end
      if (c == 516) begin
        checks++; if (wp_idx !== 3'd0) begin failures++; $display("FAIL two_idx_hold got=%0d exp=0", wp_idx); end
      end
      if (c == 518) begin
        checks++; if (wp_idx !== 3'd1) begin failures++; $display("FAIL two_idx_adv got=%0d exp=1", wp_idx); end
      end
      if (c == 521) begin
        checks++; if (pos !== 32'h808080FE) begin failures++; $display("FAIL two_wp1_step got=%h exp=808080FE", pos); end
      end
      if ((prev0 == 8'hFF && pos[7:0] == 8'h00) || (prev0 == 8'h00 && pos[7:0] == 8'hFF)) wraps++;
      if (pos[7:0] > max0) max0 = pos[7:0];
      prev0 = pos[7:0];
      if (done) begin
        ndone++;
        if (done_at == 0) done_at = c;
      end
    end
    checks++; if (done_at !== 1034) begin failures++; $display("FAIL two_done_time got=%0d exp=1034", done_at); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL two_done_count got=%0d exp=1", ndone); end
    checks++; if (wraps !== 0) begin failures++; $display("FAIL two_no_wrap got=%0d exp=0", wraps); end
    checks++; if (max0 !== 8'hFF) begin failures++; $display("FAIL two_max_joint0 got=%h exp=FF", max0); end
    checks++; if (pos !== 32'h80808080) begin failures++; $display("FAIL two_final_pos got=%h exp=80808080", pos); end
  endtask

  task automatic test_stop();
    int ndone;
    ndone = 0;
    do_reset();
    write_wp(3'd0, 32'h80808081);
    write_wp(3'd1, 32'h80808090);
    pulse_start(3'd1);
    repeat (22) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b exp=0", busy); end
    checks++; if (pos !== 32'h80808083) begin failures++; $display("FAIL stop_pos got=%h exp=80808083", pos); end
    checks++; if (wp_idx !== 3'd1) begin failures++; $display("FAIL stop_wp_idx got=%0d exp=1", wp_idx); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL stop_done got=%b exp=0", done); end
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (done) ndone++;
    end
    checks++; if (pos !== 32'h80808083) begin failures++; $display("FAIL stop_frozen got=%h exp=80808083", pos); end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL stop_no_done got=%0d exp=0", ndone); end
    pulse_start(3'd1);
    checks++; if (wp_idx !== 3'd0) begin failures++; $display("FAIL restart_wp_idx got=%0d exp=0", wp_idx); end
    repeat (8) cyc();
    checks++; if (pos !== 32'h80808081) begin failures++; $display("FAIL restart_pos got=%h exp=80808081", pos); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_start_stop_and_drop();
    int done_at;
    int ndone;
    done_at = 0;
    ndone = 0;
    do_reset();
    write_wp(3'd0, 32'h80808082);
    start = 1'b1;
    stop = 1'b1;
    last_wp = 3'd0;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL startstop_busy got=%b exp=0", busy); end
    cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL startstop_busy_later got=%b exp=0", busy); end
    pulse_start(3'd0);
    write_wp(3'd0, 32'h80808090);
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (done) ndone++;
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL drop_run1_done got=%0d exp=1", ndone); end
    checks++; if (pos !== 32'h80808082) begin failures++; $display("FAIL drop_run1_pos got=%h exp=80808082", pos); end
    pulse_start(3'd0);
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (done && done_at == 0) done_at = c;
    end
    checks++; if (done_at !== 9) begin failures++; $display("FAIL zero_tick_done_time got=%0d exp=9", done_at); end
    checks++; if (pos !== 32'h80808082) begin failures++; $display("FAIL drop_run2_pos got=%h exp=80808082", pos); end
  endtask

  task automatic test_reset_in_hold();
    int ndone;
    int done_at;
    ndone = 0;
    done_at = 0;
    pulse_start(3'd0);
    repeat (3) cyc();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy got=%b exp=1", busy); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++; if (pos !== 32'h80808080) begin failures++; $display("FAIL midreset_pos got=%h exp=80808080", pos); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
    for (int c = 1; c <= 15; c++) begin
      cyc();
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", ndone); end
    pulse_start(3'd0);
    for (int c = 1; c <= 30; c++) begin
      cyc();
      if (done && done_at == 0) done_at = c;
    end
    checks++; if (done_at !== 9) begin failures++; $display("FAIL table_reset_done_time got=%0d exp=9", done_at); end
    checks++; if (pos !== 32'h80808080) begin failures++; $display("FAIL table_reset_pos got=%h exp=80808080", pos); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_wp();
    test_stop();
    test_start_stop_and_drop();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
